// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the select pair and one-hot grant of a shared 4-to-1 mux.
// Optional hold-time pre-emption is enabled by defining MUX_ARB_TIMEOUT_EN.
module mux4_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = $clog2(MAX_HOLD) + 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic       sel0,
  output logic       sel1,
  output logic       busy
);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t     r_state, w_state_nxt;
  logic [1:0] r_owner, w_owner_nxt;
  logic [1:0] r_last, w_last_nxt;
  logic [3:0] r_gnt;
  logic       r_busy;
  logic [1:0] r_sel;
  logic [2:0] w_pick;
  logic       w_release;

  if (MAX_HOLD < 2 || CNT_W != $clog2(MAX_HOLD) + 1) begin : g_param_check
    $error("mux4_rr_arbiter: MAX_HOLD must be >= 2 and CNT_W must stay derived");
  end

  // First set request after base in RR order; {found, index}. incl_base allows base itself last.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] base,
                                         input logic incl_base);
    logic       found;
    logic [1:0] pick;
    logic [1:0] idx;
    found = 1'b0;
    pick  = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      idx = base + 2'(k);
      if (!found && r[idx] && (k != 4 || incl_base)) begin
        found = 1'b1;
        pick  = idx;
      end
    end
    return {found, pick};
  endfunction

`ifdef MUX_ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]       w_others;

  assign w_others  = req & ~(4'b0001 << r_owner);
  assign w_release = !req[r_owner] || ((r_cnt >= CNT_MAX) && (|w_others));

  // Counter restarts on every new grant and saturates while the owner keeps it.
  always_comb begin
    w_cnt_nxt = '0;
    if (r_state == S_GRANT && !w_release) begin
      w_cnt_nxt = (r_cnt >= CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_cnt <= '0;
    else     r_cnt <= w_cnt_nxt;
  end
`else
  assign w_release = !req[r_owner];
`endif

  // Next owner: from IDLE the scan includes the last owner, on release it excludes it.
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    w_pick      = (r_state == S_IDLE) ? rr_pick(req, r_last, 1'b1)
                                      : rr_pick(req, r_owner, 1'b0);
    case (r_state)
      S_IDLE: begin
        if (w_pick[2]) begin
          w_state_nxt = S_GRANT;
          w_owner_nxt = w_pick[1:0];
        end
      end
      S_GRANT: begin
        if (w_release) begin
          w_last_nxt = r_owner;
          if (w_pick[2]) w_owner_nxt = w_pick[1:0];
          else           w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_owner <= 2'd0;
      r_last  <= 2'd3;
      r_gnt   <= 4'b0000;
      r_busy  <= 1'b0;
      r_sel   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
      r_gnt   <= (w_state_nxt == S_GRANT) ? (4'b0001 << w_owner_nxt) : 4'b0000;
      r_busy  <= (w_state_nxt == S_GRANT);
      r_sel   <= w_owner_nxt;
    end
  end

  assign gnt  = r_gnt;
  assign busy = r_busy;
  assign sel0 = r_sel[0];
  assign sel1 = r_sel[1];

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: directed scenarios plus random requests vs a model.
module tb_mux4_rr_arbiter;

  localparam int MAX_HOLD = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic       sel0, sel1, busy;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model state: who holds the mux, the previous owner, and grant cycles shown so far.
  bit m_busy  = 1'b0;
  int m_owner = 0;
  int m_last  = 3;
  int m_held  = 0;

  mux4_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .gnt  (gnt),
    .sel0 (sel0),
    .sel1 (sel1),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] model_gnt();
    return m_busy ? 4'(1 << m_owner) : 4'b0000;
  endfunction

  // Advance the model by one clock edge using the inputs about to be sampled.
  task automatic model_edge(input logic r, input logic [3:0] q);
    bit preempt;
    bit found;
    if (r) begin
      m_busy = 1'b0; m_owner = 0; m_last = 3; m_held = 0;
    end else if (!m_busy) begin
      found = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        int c = (m_last + k) % 4;
        if (!found && q[c]) begin
          found = 1'b1; m_busy = 1'b1; m_owner = c; m_held = 1;
        end
      end
    end else begin
      preempt = 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
      for (int c = 0; c < 4; c++)
        if (c != m_owner && q[c] && m_held >= MAX_HOLD) preempt = 1'b1;
`endif
      if (q[m_owner] && !preempt) begin
        m_held++;
      end else begin
        m_last = m_owner;
        found  = 1'b0;
        for (int k = 1; k <= 3; k++) begin
          int c = (m_owner + k) % 4;
          if (!found && q[c]) begin
            found = 1'b1; m_owner = c; m_held = 1;
          end
        end
        if (!found) begin
          m_busy = 1'b0; m_held = 0;
        end
      end
    end
  endtask

  // One cycle: drive at the falling edge, let the rising edge pass, compare at the next falling edge.
  task automatic step(input logic r, input logic [3:0] q);
    rst = r;
    req = q;
    model_edge(r, q);
    @(posedge clk);
    @(negedge clk);
    check("gnt", gnt, model_gnt());
    check("sel", {2'b00, sel1, sel0}, 4'(m_owner));
    check("busy", {3'b000, busy}, {3'b000, m_busy});
  endtask

  task automatic pin(input string name, input logic [3:0] g, input logic [1:0] s,
                     input logic b);
    check({name, "_gnt"}, gnt, g);
    check({name, "_sel"}, {2'b00, sel1, sel0}, {2'b00, s});
    check({name, "_busy"}, {3'b000, busy}, {3'b000, b});
    check({name, "_model"}, model_gnt(), g);
  endtask

  initial begin
    logic [3:0] q;
    logic       r;
    @(negedge clk);

    step(1'b1, 4'b1111); pin("rst_a", 4'b0000, 2'd0, 1'b0);
    step(1'b1, 4'b1111); pin("rst_b", 4'b0000, 2'd0, 1'b0);
    step(1'b0, 4'b0110); pin("first", 4'b0010, 2'd1, 1'b1);
    step(1'b0, 4'b0100); pin("handover", 4'b0100, 2'd2, 1'b1);
    step(1'b0, 4'b0000); pin("to_idle", 4'b0000, 2'd2, 1'b0);
    step(1'b0, 4'b1000); pin("own3", 4'b1000, 2'd3, 1'b1);
    step(1'b0, 4'b1001); pin("hold3", 4'b1000, 2'd3, 1'b1);
    step(1'b0, 4'b0001); pin("wrap", 4'b0001, 2'd0, 1'b1);
    step(1'b0, 4'b0100); pin("own2", 4'b0100, 2'd2, 1'b1);
    step(1'b1, 4'b1111); pin("mid_rst", 4'b0000, 2'd0, 1'b0);
    step(1'b0, 4'b1111); pin("post_rst", 4'b0001, 2'd0, 1'b1);

    // Two requesters held constantly: owner 0 keeps 8 cycles, then pre-emption if enabled.
    step(1'b1, 4'b0000);
    step(1'b0, 4'b0011); pin("hold_c1", 4'b0001, 2'd0, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b0, 4'b0011);
    pin("hold_c8", 4'b0001, 2'd0, 1'b1);
    step(1'b0, 4'b0011);
`ifdef MUX_ARB_TIMEOUT_EN
    pin("hold_c9", 4'b0010, 2'd1, 1'b1);
`else
    pin("hold_c9", 4'b0001, 2'd0, 1'b1);
`endif
    for (int i = 0; i < 20; i++) step(1'b0, 4'b0001);
    pin("solo", 4'b0001, 2'd0, 1'b1);

    // Random requests that mostly persist, with occasional resets.
    q = 4'b0000;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(5) == 0) q[b] = ~q[b];
      r = ($urandom_range(79) == 0);
      step(r, q);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
